// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader: default sizing, halt encoding,
// loader state enum and a small byte-sum helper.
package imem_pkg;

    localparam int          SIZE_IM_DEF   = 128;
    localparam logic [31:0] HALT_WORD_DEF = 32'hFC00_0000;
    localparam logic [5:0]  HALT_OPCODE   = 6'b111111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHECK = 3'd3,
`endif
        ST_DONE  = 3'd4
    } ld_state_e;

    function automatic logic [7:0] sum8(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/imem_word_assembler.sv
// Byte-to-word packer: shifts accepted bytes in big-endian order and flags the 4th byte.
module imem_word_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_ready
);

    logic [23:0] shift_q, shift_d;
    logic [1:0]  cnt_q, cnt_d;

    // Next-state for the shift register and byte counter; clear wins over accept.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (clear) begin
            shift_d = 24'd0;
            cnt_d   = 2'd0;
        end else if (accept) begin
            shift_d = {shift_q[15:0], byte_in};
            cnt_d   = cnt_q + 2'd1;
        end else begin
            shift_d = shift_q;
            cnt_d   = cnt_q;
        end
    end

    // Shift register and counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= 24'd0;
            cnt_q   <= 2'd0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    // The full word includes the byte being accepted this cycle.
    assign word       = {shift_q, byte_in};
    assign word_ready = accept && !clear && (cnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Streams bytes into 32-bit words and writes them to instruction memory from address 0.
// Optional IMEM_LOADER_CHECKSUM_EN adds a trailing 8-bit checksum byte after the halt word.
module imem_loader
    import imem_pkg::*;
#(
    parameter int          SIZE_IM   = SIZE_IM_DEF,
    parameter logic [31:0] HALT_WORD = HALT_WORD_DEF
) (
    input  logic                       i_Clk,
    input  logic                       i_Rst_n,
    input  logic                       i_Start,
    input  logic [7:0]                 i_Byte,
    input  logic                       i_Byte_Valid,
    output logic                       o_Byte_Ready,
    output logic                       o_We,
    output logic [31:0]                o_Waddr,
    output logic [31:0]                o_Wdata,
    output logic                       o_Cpu_Hold,
    output logic                       o_Done,
    output logic [$clog2(SIZE_IM):0]   o_Words,
    output logic                       o_Err
);

    localparam int IDX_W   = (SIZE_IM > 1) ? $clog2(SIZE_IM) : 1;
    localparam int WORDS_W = $clog2(SIZE_IM) + 1;

    ld_state_e           state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WORDS_W-1:0]  words_q, words_d;
    logic                we_q, we_d;
    logic [31:0]         waddr_q, waddr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                ready_q, ready_d;
    logic                hold_q, hold_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                accept_s;
    logic                asm_accept_s;
    logic [31:0]         asm_word_s;
    logic                asm_ready_s;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]          sum_q, sum_d;
`endif

    assign accept_s     = i_Byte_Valid && ready_q;
    assign asm_accept_s = accept_s && (state_q == ST_RECV);

    imem_word_assembler u_asm (
        .clk        (i_Clk),
        .rst_n      (i_Rst_n),
        .clear      (i_Start),
        .accept     (asm_accept_s),
        .byte_in    (i_Byte),
        .word       (asm_word_s),
        .word_ready (asm_ready_s)
    );

    // Next-state and output decode; i_Start restarts the load from any state.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        words_d = words_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        if (i_Start) begin
            state_d = ST_RECV;
            idx_d   = {IDX_W{1'b0}};
            words_d = {WORDS_W{1'b0}};
            err_d   = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_d   = 8'd0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_RECV: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    if (asm_accept_s) begin
                        sum_d = sum8(sum_q, i_Byte);
                    end else begin
                        sum_d = sum_q;
                    end
`endif
                    if (asm_ready_s) begin
                        state_d = ST_WRITE;
                        we_d    = 1'b1;
                        waddr_d = 32'({idx_q, 2'b00});
                        wdata_d = asm_word_s;
                        words_d = words_q + WORDS_W'(1);
                    end else begin
                        state_d = ST_RECV;
                    end
                end
                ST_WRITE: begin
                    if (wdata_q == HALT_WORD) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = ST_CHECK;
`else
                        state_d = ST_DONE;
`endif
                    end else if (idx_q == IDX_W'(SIZE_IM - 1)) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_RECV;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (accept_s) begin
                        state_d = ST_DONE;
                        err_d   = (i_Byte != sum_q);
                    end else begin
                        state_d = ST_CHECK;
                    end
                end
`endif
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Status outputs are registered copies of the decoded next state.
`ifdef IMEM_LOADER_CHECKSUM_EN
        ready_d = (state_d == ST_RECV) || (state_d == ST_CHECK);
        hold_d  = (state_d == ST_RECV) || (state_d == ST_WRITE) || (state_d == ST_CHECK);
`else
        ready_d = (state_d == ST_RECV);
        hold_d  = (state_d == ST_RECV) || (state_d == ST_WRITE);
`endif
        done_d  = (state_d == ST_DONE);
    end

    // State and registered outputs.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= {IDX_W{1'b0}};
            words_q <= {WORDS_W{1'b0}};
            we_q    <= 1'b0;
            waddr_q <= 32'd0;
            wdata_q <= 32'd0;
            ready_q <= 1'b0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            words_q <= words_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    assign o_Byte_Ready = ready_q;
    assign o_We         = we_q;
    assign o_Waddr      = waddr_q;
    assign o_Wdata      = wdata_q;
    assign o_Cpu_Hold   = hold_q;
    assign o_Done       = done_q;
    assign o_Words      = words_q;
    assign o_Err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed scoreboard bench for imem_loader: a default-size instance and a 4-word instance.
module tb_imem_loader;
    import imem_pkg::*;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n, start_big, start_small, valid;
    logic [7:0]  bdata;

    logic        b_rdy, b_we, b_hold, b_done, b_err;
    logic [31:0] b_waddr, b_wdata;
    logic [7:0]  b_words;
    logic        s_rdy, s_we, s_hold, s_done, s_err;
    logic [31:0] s_waddr, s_wdata;
    logic [2:0]  s_words;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          s_writes = 0;
    wr_t         q_big[$];
    wr_t         q_small[$];
    logic [7:0]  model_sum;

    always #5 clk = ~clk;

    imem_loader u_big (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Start(start_big), .i_Byte(bdata),
        .i_Byte_Valid(valid), .o_Byte_Ready(b_rdy), .o_We(b_we), .o_Waddr(b_waddr),
        .o_Wdata(b_wdata), .o_Cpu_Hold(b_hold), .o_Done(b_done), .o_Words(b_words),
        .o_Err(b_err)
    );

    imem_loader #(.SIZE_IM(4)) u_small (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Start(start_small), .i_Byte(bdata),
        .i_Byte_Valid(valid), .o_Byte_Ready(s_rdy), .o_We(s_we), .o_Waddr(s_waddr),
        .o_Wdata(s_wdata), .o_Cpu_Hold(s_hold), .o_Done(s_done), .o_Words(s_words),
        .o_Err(s_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Write monitor for the default-size instance.
    always @(negedge clk) begin
        wr_t e;
        if (b_we === 1'b1) begin
            check("big_rdy_in_write", {31'd0, b_rdy}, 32'd0);
            check("big_write_expected", 32'(q_big.size() > 0), 32'd1);
            if (q_big.size() > 0) begin
                e = q_big.pop_front();
                check("big_waddr", b_waddr, e.a);
                check("big_wdata", b_wdata, e.d);
            end
        end
    end

    // Write monitor for the 4-word instance.
    always @(negedge clk) begin
        wr_t e;
        if (s_we === 1'b1) begin
            s_writes++;
            check("small_write_expected", 32'(q_small.size() > 0), 32'd1);
            if (q_small.size() > 0) begin
                e = q_small.pop_front();
                check("small_waddr", s_waddr, e.a);
                check("small_wdata", s_wdata, e.d);
            end
        end
    end

    task automatic push_big(input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        q_big.push_back(e);
    endtask

    task automatic push_small(input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        q_small.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit sel);
        bit got;
        got   = 1'b0;
        bdata = b;
        valid = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if ((sel ? s_rdy : b_rdy) === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check("byte_accept", {31'd0, got}, 32'd1);
        if (got) begin
            @(posedge clk);
            #1;
            model_sum = model_sum + b;
        end
        valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit sel, input bit gap);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[31-8*i -: 8], sel);
            if (gap && i < 3) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic do_start(input bit sel);
        @(negedge clk);
        if (sel) start_small = 1'b1;
        else     start_big   = 1'b1;
        @(posedge clk);
        #1;
        start_small = 1'b0;
        start_big   = 1'b0;
        model_sum   = 8'd0;
        check("start_hold", {31'd0, (sel ? s_hold : b_hold)}, 32'd1);
        check("start_rdy",  {31'd0, (sel ? s_rdy : b_rdy)}, 32'd1);
    endtask

    task automatic send_csum(input logic [7:0] cs);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(cs, 1'b0);
`else
        bdata = cs;
`endif
    endtask

    task automatic wait_done(input bit sel);
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if ((sel ? s_done : b_done) === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", {31'd0, seen}, 32'd1);
    endtask

    initial begin
        logic [7:0] cs;
        rst_n = 1'b0; start_big = 1'b0; start_small = 1'b0; valid = 1'b0; bdata = 8'd0;
        model_sum = 8'd0;
        repeat (2) @(negedge clk);
        check("reset_flags", {27'd0, b_rdy, b_we, b_hold, b_done, b_err}, 32'd0);
        check("reset_words", 32'(b_words), 32'd0);
        rst_n = 1'b1;

        // Basic two-word load ending in the halt word.
        do_start(1'b0);
        push_big(32'h0, 32'h2008_0005);
        push_big(32'h4, 32'hFC00_0000);
        send_word(32'h2008_0005, 1'b0, 1'b0);
        check("we_after_4th",  {31'd0, b_we}, 32'd1);
        check("rdy_low_write", {31'd0, b_rdy}, 32'd0);
        @(posedge clk);
        #1;
        check("rdy_back_high", {31'd0, b_rdy}, 32'd1);
        send_word(32'hFC00_0000, 1'b0, 1'b0);
        cs = model_sum;
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_csum(cs);
`else
        @(posedge clk);
        #1;
        check("done_at_w1", {31'd0, b_done}, 32'd1);
        check("hold_at_w1", {31'd0, b_hold}, 32'd0);
`endif
        wait_done(1'b0);
        check("t1_words", 32'(b_words), 32'd2);
        check("t1_err", {31'd0, b_err}, 32'd0);
        check("t1_hold", {31'd0, b_hold}, 32'd0);
        check("t1_rdy_done", {31'd0, b_rdy}, 32'd0);
        check("t1_q_empty", 32'(q_big.size()), 32'd0);

        // Same stream with gaps between bytes.
        do_start(1'b0);
        push_big(32'h0, 32'h2008_0005);
        push_big(32'h4, 32'hFC00_0000);
        send_word(32'h2008_0005, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        send_word(32'hFC00_0000, 1'b0, 1'b1);
        cs = model_sum;
        send_csum(cs);
        wait_done(1'b0);
        check("t2_words", 32'(b_words), 32'd2);
        check("t2_err", {31'd0, b_err}, 32'd0);
        check("t2_q_empty", 32'(q_big.size()), 32'd0);

        // Memory-full on the 4-word instance.
        do_start(1'b1);
        for (int i = 0; i < 4; i++) begin
            push_small(32'(i * 4), 32'h0102_0300 + 32'(i));
        end
        for (int i = 0; i < 4; i++) begin
            send_word(32'h0102_0300 + 32'(i), 1'b1, 1'b0);
        end
        wait_done(1'b1);
        check("full_err", {31'd0, s_err}, 32'd1);
        check("full_words", 32'(s_words), 32'd4);
        repeat (6) @(negedge clk);
        check("full_write_count", 32'(s_writes), 32'd4);
        check("full_q_empty", 32'(q_small.size()), 32'd0);

        // Reset mid-word, then a fresh word.
        do_start(1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_flags", {27'd0, b_rdy, b_we, b_hold, b_done, b_err}, 32'd0);
        check("rst_waddr", b_waddr, 32'd0);
        check("rst_wdata", b_wdata, 32'd0);
        check("rst_words", 32'(b_words), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_start(1'b0);
        push_big(32'h0, 32'h1122_3344);
        send_word(32'h1122_3344, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("t4_q_empty", 32'(q_big.size()), 32'd0);
        check("t4_words", 32'(b_words), 32'd1);

        // Restart after one word; halt lands at address 0.
        do_start(1'b0);
        push_big(32'h0, 32'hAABB_CCDD);
        send_word(32'hAABB_CCDD, 1'b0, 1'b0);
        do_start(1'b0);
        push_big(32'h0, 32'hFC00_0000);
        send_word(32'hFC00_0000, 1'b0, 1'b0);
        cs = model_sum;
        send_csum(cs);
        wait_done(1'b0);
        check("t5_words", 32'(b_words), 32'd1);
        check("t5_err", {31'd0, b_err}, 32'd0);
        check("t5_q_empty", 32'(q_big.size()), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum good and bad.
        for (int k = 0; k < 2; k++) begin
            do_start(1'b0);
            push_big(32'h0, 32'h0102_0304);
            push_big(32'h4, 32'hFC00_0000);
            send_word(32'h0102_0304, 1'b0, 1'b0);
            send_word(32'hFC00_0000, 1'b0, 1'b0);
            cs = (k == 0) ? model_sum : 8'h00;
            send_byte(cs, 1'b0);
            check("csum_done_next", {31'd0, b_done}, 32'd1);
            check("csum_err", {31'd0, b_err}, {31'd0, (k == 1)});
            check("csum_q_empty", 32'(q_big.size()), 32'd0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

endmodule
